alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_sequencer.sv | 107 ++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer.
//   state_t : sequencer FSM states (IDLE, EXEC, DONE)
//   OP_*    : 3-bit opcodes understood by the external ALU
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;  // B + C
    localparam logic [2:0] OP_PASS  = 3'b001;  // B
    localparam logic [2:0] OP_PASS2 = 3'b010;  // B
    localparam logic [2:0] OP_SRA   = 3'b011;  // B >>> 2
    localparam logic [2:0] OP_AND   = 3'b100;  // A & B
    localparam logic [2:0] OP_OR    = 3'b101;  // A | B
    localparam logic [2:0] OP_NOT   = 3'b110;  // ~B
    localparam logic [2:0] OP_ZERO  = 3'b111;  // 0

endpackage

// File: rtl/alu_sequencer.sv
// Sequences single commands through an external combinational ALU.
// A command (opcode, operand B, carry) is accepted in IDLE, presented to
// the ALU for one EXEC cycle with the accumulator as operand A, and the
// result is written back to the accumulator and held on out_* in DONE
// until the consumer takes it.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : command handshake
//   in_opc, in_data, in_carry    : command opcode, operand B, carry-in
//   alu_a, alu_b, alu_opc, alu_c : operands/opcode/carry driven to the ALU
//   alu_w, alu_zer, alu_neg      : ALU result and flags
//   out_valid/out_ready          : result handshake
//   out_data, out_zer, out_neg   : registered result and flags
//   op_cnt                       : completed writebacks, wraps
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_opc,
    input  logic [W-1:0]  in_data,
    input  logic          in_carry,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_opc,
    output logic          alu_c,
    input  logic [W-1:0]  alu_w,
    input  logic          alu_zer,
    input  logic          alu_neg,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_zer,
    output logic          out_neg,
    output logic [CW-1:0] op_cnt
);

    state_t        state;
    logic [W-1:0]  acc;

    // Operand A to the ALU is always the accumulator.
    assign alu_a = acc;

    // Sequencer FSM with registered handshake, operand and result outputs.
    // alu_b/alu_opc act as the operand registers; alu_c is only non-zero
    // while in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            out_data  <= '0;
            out_zer   <= 1'b1;
            out_neg   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            alu_b     <= '0;
            alu_opc   <= OP_ADD;
            alu_c     <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        alu_b    <= in_data;
                        alu_opc  <= in_opc;
                        alu_c    <= in_carry;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    acc       <= alu_w;
                    out_data  <= alu_w;
                    out_zer   <= alu_zer;
                    out_neg   <= alu_neg;
                    op_cnt    <= op_cnt + {{(CW-1){1'b0}}, 1'b1};
                    out_valid <= 1'b1;
                    alu_c     <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state     <= DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    alu_c     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, reference model
// with expectation queue, and a decoupled output monitor.
module tb_alu_sequencer;

    localparam int W  = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_opc;
    logic [W-1:0]  in_data;
    logic          in_carry;
    logic [W-1:0]  alu_a, alu_b, alu_w;
    logic [2:0]    alu_opc;
    logic          alu_c, alu_zer, alu_neg;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic          out_zer, out_neg;
    logic [CW-1:0] op_cnt;

    logic hold_rdy = 1'b1;
    logic rdy_rand = 1'b0;
    logic rnd_bit  = 1'b1;

    assign out_ready = rdy_rand ? rnd_bit : hold_rdy;

    always #5 clk = ~clk;

    alu_sequencer #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opc(in_opc), .in_data(in_data), .in_carry(in_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc), .alu_c(alu_c),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zer(out_zer), .out_neg(out_neg),
        .op_cnt(op_cnt)
    );

    // ALU behaviour by opcode, as plain arithmetic.
    function automatic logic [W-1:0] alu_rule(input logic [2:0] opc,
            input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        case (opc)
            3'd0:    return b + {{(W-1){1'b0}}, c};
            3'd1:    return b;
            3'd2:    return b;
            3'd3:    return W'($signed(b) >>> 2);
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return ~b;
            default: return '0;
        endcase
    endfunction

    // The external combinational ALU.
    always_comb begin
        alu_w   = alu_rule(alu_opc, alu_a, alu_b, alu_c);
        alu_zer = (alu_w == '0);
        alu_neg = alu_w[W-1];
    end

    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    typedef struct {
        logic [W-1:0]  d;
        logic          z;
        logic          n;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_acc = '0;
    int           m_cnt = 0;
    int           tests = 0;
    int           fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: first cycle of each out_valid pops an expectation; later
    // cycles of the same DONE check the outputs stay put.
    exp_t cur;
    bit   seen = 1'b0;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!seen) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h, wanted no output", out_data);
                end else begin
                    cur = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(cur.d));
                    chk("out_zer",  32'(out_zer),  32'(cur.z));
                    chk("out_neg",  32'(out_neg),  32'(cur.n));
                    chk("op_cnt",   32'(op_cnt),   32'(cur.cnt));
                    chk("alu_c_done", 32'(alu_c),  32'd0);
                end
                seen = 1'b1;
            end else begin
                chk("hold_data", 32'(out_data), 32'(cur.d));
                chk("hold_cnt",  32'(op_cnt),   32'(cur.cnt));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Offer one command, update the model on acceptance, check EXEC drive.
    task automatic send(input logic [2:0] opc, input logic [W-1:0] d, input logic c);
        int n = 0;
        logic [W-1:0] r;
        logic [W-1:0] a_before;
        @(negedge clk);
        in_valid = 1'b1; in_opc = opc; in_data = d; in_carry = c;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0, wanted 1");
            in_valid = 1'b0;
            return;
        end
        a_before = m_acc;
        r = alu_rule(opc, m_acc, d, c);
        m_acc = r;
        m_cnt = (m_cnt + 1) % (1 << CW);
        q.push_back('{r, (r == '0), r[W-1], CW'(m_cnt)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_opc   = 3'($urandom);
        in_data  = W'($urandom);
        in_carry = 1'($urandom);
        @(negedge clk);
        chk("exec_alu_a",   32'(alu_a),    32'(a_before));
        chk("exec_alu_b",   32'(alu_b),    32'(d));
        chk("exec_alu_opc", 32'(alu_opc),  32'(opc));
        chk("exec_alu_c",   32'(alu_c),    32'(c));
        chk("exec_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, wanted 0", q.size());
        end
    endtask

    initial begin
        int n;
        in_valid = 1'b0; in_opc = 3'd0; in_data = '0; in_carry = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_op_cnt",    32'(op_cnt),    32'd0);
        chk("rst_acc",       32'(alu_a),     32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_zer",   32'(out_zer),   32'd1);
        chk("rst_out_neg",   32'(out_neg),   32'd0);
        chk("rst_alu_b",     32'(alu_b),     32'd0);
        chk("rst_alu_opc",   32'(alu_opc),   32'd0);
        chk("rst_alu_c",     32'(alu_c),     32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_in_ready",  32'(in_ready),  32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Directed: overflow add, accumulate chain, shift, invert.
        send(3'b000, 16'h7FFF, 1'b1);
        send(3'b001, 16'h00F0, 1'b0);
        send(3'b100, 16'h0FF0, 1'b0);
        send(3'b101, 16'h000F, 1'b1);
        send(3'b011, 16'hFFF8, 1'b0);
        send(3'b110, 16'hFFFF, 1'b0);
        drain();

        // Consumer stalls five cycles while new commands are offered.
        hold_rdy = 1'b0;
        send(3'b010, 16'h1234, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            in_opc   = 3'($urandom);
            in_data  = W'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold_rdy = 1'b1;
        drain();

        // Reset during EXEC aborts the command.
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1; in_opc = 3'b001; in_data = 16'h5555; in_carry = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_acc = '0;
        m_cnt = 0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_acc",       32'(alu_a),     32'd0);
        chk("abort_op_cnt",    32'(op_cnt),    32'd0);
        chk("abort_alu_c",     32'(alu_c),     32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd0);

        // Randomized commands with a random consumer.
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(3'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();
        rdy_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

endmodule
